// File: rtl/trdb_packet_serializer.sv
`default_nettype none
// ============================================================================
// Module      : trdb_packet_serializer
// Description : Packs variable-length trace packets (1..PKT_W bits,
//               LSB-first) into a contiguous stream of 32-bit words on a
//               valid/ready interface. A flush request drains any partial
//               word, zero-padded, and then pulses flush_done_o.
//               Optional feature macro: TRDB_SERIALIZER_CNT_EN enables the
//               saturating packet and word counters. Without it the counter
//               outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module trdb_packet_serializer #(
    parameter int PKT_W = 128,
    parameter int LEN_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    // packet side
    input  logic             pkt_valid_i,
    output logic             pkt_ready_o,
    input  logic [PKT_W-1:0] pkt_bits_i,
    input  logic [LEN_W-1:0] pkt_len_i,
    // flush control
    input  logic             flush_i,
    output logic             flush_done_o,
    // word side
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic [31:0]      word_o,
    // statistics
    output logic [31:0]      pkt_cnt_o,
    output logic [31:0]      word_cnt_o
);

    localparam int WORD_W = 32;
    localparam int BUF_W  = PKT_W + WORD_W;
    localparam int FILL_W = $clog2(BUF_W);

    localparam logic [FILL_W-1:0] C_WORD_FILL = FILL_W'(WORD_W);
    localparam logic [LEN_W-1:0]  C_LEN_MAX   = LEN_W'(PKT_W);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // FSM and flush-done registers
    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic              done_q;
    logic              done_d;

    // bit buffer: bits at and above fill_q are always zero
    logic [BUF_W-1:0]  buf_q;
    logic [BUF_W-1:0]  buf_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;

    // handshakes and packet conditioning
    logic              w_pkt_fire;
    logic              w_word_fire;
    logic [LEN_W-1:0]  w_len_eff;
    logic [PKT_W-1:0]  w_mask;
    logic [BUF_W-1:0]  w_pkt_ext;

    // Handshakes. Accept and emit are mutually exclusive by construction:
    // ready needs fill < 32, a word in RUN needs fill >= 32, and in FLUSH no
    // packet is accepted at all.
    assign w_pkt_fire  = pkt_valid_i  & pkt_ready_o;
    assign w_word_fire = word_valid_o & word_ready_i;

    // Over-long lengths are clamped so the mask and fill arithmetic stay
    // inside the buffer; payload bits above the length are masked off to
    // keep the region above fill_q zero.
    assign w_len_eff = (pkt_len_i > C_LEN_MAX) ? C_LEN_MAX : pkt_len_i;
    assign w_mask    = ~({PKT_W{1'b1}} << w_len_eff);
    assign w_pkt_ext = {{WORD_W{1'b0}}, pkt_bits_i & w_mask};

    // State register: FSM state plus the registered flush-done pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: a flush is latched in RUN and ends once the buffer
    // has been fully drained; a repeated flush request in FLUSH is ignored.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fill_q == '0) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output logic: decoded from registers only, so nothing combinational
    // reaches an output from an input.
    always_comb begin
        pkt_ready_o  = (state_q == ST_RUN) && (fill_q < C_WORD_FILL);
        word_valid_o = (fill_q >= C_WORD_FILL) ||
                       ((state_q == ST_FLUSH) && (fill_q != '0));
        word_o       = buf_q[WORD_W-1:0];
        flush_done_o = done_q;
    end

    // Buffer register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end

    // Buffer next state: append a packet at the fill point, or retire the
    // low word. The right shift zero-fills, so a partial final word emitted
    // during a flush comes out padded with zeros above the valid bits.
    always_comb begin
        buf_d  = buf_q;
        fill_d = fill_q;
        if (w_pkt_fire && (w_len_eff != '0)) begin
            buf_d  = buf_q | (w_pkt_ext << fill_q);
            fill_d = fill_q + FILL_W'(w_len_eff);
        end else if (w_word_fire) begin
            buf_d  = buf_q >> WORD_W;
            fill_d = (fill_q >= C_WORD_FILL) ? (fill_q - C_WORD_FILL) : '0;
        end
    end

`ifdef TRDB_SERIALIZER_CNT_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] word_cnt_q;

    // Saturating statistics counters; a flush leaves them untouched
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            if (w_pkt_fire && (w_len_eff != '0) && (pkt_cnt_q != '1)) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
            if (w_word_fire && (word_cnt_q != '1)) begin
                word_cnt_q <= word_cnt_q + 32'd1;
            end
        end
    end

    assign pkt_cnt_o  = pkt_cnt_q;
    assign word_cnt_o = word_cnt_q;
`else
    assign pkt_cnt_o  = '0;
    assign word_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_trdb_packet_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trdb_packet_serializer
// Description : Self-checking bench for trdb_packet_serializer. A bit-queue
//               reference model predicts every output each cycle; directed
//               cases pin known words and flush timing with literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trdb_packet_serializer;

    localparam int PKT_W = 128;
    localparam int LEN_W = 8;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             pkt_valid_i;
    logic             pkt_ready_o;
    logic [PKT_W-1:0] pkt_bits_i;
    logic [LEN_W-1:0] pkt_len_i;
    logic             flush_i;
    logic             flush_done_o;
    logic             word_valid_o;
    logic             word_ready_i;
    logic [31:0]      word_o;
    logic [31:0]      pkt_cnt_o;
    logic [31:0]      word_cnt_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int rdy_mode = 0; // 0 high, 1 toggle, 2 random, 3 low

    always #5 clk_i = ~clk_i;

    trdb_packet_serializer #(
        .PKT_W(PKT_W),
        .LEN_W(LEN_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .pkt_valid_i (pkt_valid_i),
        .pkt_ready_o (pkt_ready_o),
        .pkt_bits_i  (pkt_bits_i),
        .pkt_len_i   (pkt_len_i),
        .flush_i     (flush_i),
        .flush_done_o(flush_done_o),
        .word_valid_o(word_valid_o),
        .word_ready_i(word_ready_i),
        .word_o      (word_o),
        .pkt_cnt_o   (pkt_cnt_o),
        .word_cnt_o  (word_cnt_o)
    );

    // ---------------- reference model: stream of pending bits ----------------
    bit          mq[$];
    bit          m_flush;
    bit          m_done;
    logic [31:0] m_pcnt;
    logic [31:0] m_wcnt;

    function automatic bit m_ready();
        return !m_flush && (mq.size() < 32);
    endfunction

    function automatic bit m_valid();
        return (mq.size() >= 32) || (m_flush && (mq.size() > 0));
    endfunction

    function automatic logic [31:0] m_word();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32 && i < mq.size(); i++) w[i] = mq[i];
        return w;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin : model
        int  sz;
        int  len;
        bit  pf;
        bit  wf;
        bit  nd;
        if (!rst_ni) begin
            mq.delete();
            m_flush = 1'b0;
            m_done  = 1'b0;
            m_pcnt  = '0;
            m_wcnt  = '0;
        end else begin
            sz = mq.size();
            pf = pkt_valid_i && m_ready();
            wf = m_valid() && word_ready_i;
            nd = m_flush && (sz == 0);
            if (pf) begin
                len = (int'(pkt_len_i) > PKT_W) ? PKT_W : int'(pkt_len_i);
                for (int i = 0; i < len; i++) mq.push_back(pkt_bits_i[i]);
                if (len > 0 && m_pcnt != 32'hFFFF_FFFF) m_pcnt = m_pcnt + 1;
            end
            if (wf) begin
                for (int i = 0; i < 32 && mq.size() > 0; i++) void'(mq.pop_front());
                if (m_wcnt != 32'hFFFF_FFFF) m_wcnt = m_wcnt + 1;
            end
            if (!m_flush && flush_i) m_flush = 1'b1;
            else if (m_flush && sz == 0) m_flush = 1'b0;
            m_done = nd;
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk_i) begin
        if (chk_en) begin
            check32("pkt_ready",  {31'b0, pkt_ready_o},  {31'b0, m_ready()});
            check32("word_valid", {31'b0, word_valid_o}, {31'b0, m_valid()});
            check32("flush_done", {31'b0, flush_done_o}, {31'b0, m_done});
            if (m_valid()) check32("word", word_o, m_word());
`ifdef TRDB_SERIALIZER_CNT_EN
            check32("pkt_cnt",  pkt_cnt_o,  m_pcnt);
            check32("word_cnt", word_cnt_o, m_wcnt);
`else
            check32("pkt_cnt",  pkt_cnt_o,  32'd0);
            check32("word_cnt", word_cnt_o, 32'd0);
`endif
        end
    end

    // word_ready_i pattern generator
    initial begin
        word_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (rdy_mode)
                0:       word_ready_i = 1'b1;
                1:       word_ready_i = ~word_ready_i;
                2:       word_ready_i = 1'($urandom_range(0, 1));
                default: word_ready_i = 1'b0;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_pkt(input logic [PKT_W-1:0] bits, input logic [LEN_W-1:0] len,
                            input bit with_flush);
        int n;
        bit fired;
        pkt_valid_i = 1'b1;
        pkt_bits_i  = bits;
        pkt_len_i   = len;
        flush_i     = with_flush;
        n = 0;
        fired = 1'b0;
        while (!fired && n < 200) begin
            @(negedge clk_i);
            fired = pkt_ready_o;
            @(posedge clk_i);
            #1;
            flush_i = 1'b0;
            n++;
        end
        pkt_valid_i = 1'b0;
        pkt_bits_i  = '0;
        pkt_len_i   = '0;
        if (!fired) begin
            checks++;
            errors++;
            $display("FAIL pkt_accept_timeout: got no accept expected accept within 200 cycles");
        end
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
    endtask

    task automatic wait_word(input logic [31:0] exp, input string name);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk_i);
            if (word_valid_o && word_ready_i) begin
                seen = 1'b1;
                check32(name, word_o, exp);
            end
            n++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no word expected %h", name, exp);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk_i);
            seen = flush_done_o;
            n++;
        end
        check32(name, {31'b0, seen}, 32'd1);
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_ni      = 1'b0;
        pkt_valid_i = 1'b0;
        pkt_bits_i  = '0;
        pkt_len_i   = '0;
        flush_i     = 1'b0;

        // reset held for 5 cycles
        repeat (5) @(posedge clk_i);
        #1;
        check32("rst_pkt_ready",  {31'b0, pkt_ready_o},  32'd1);
        check32("rst_word_valid", {31'b0, word_valid_o}, 32'd0);
        check32("rst_word",       word_o,                32'd0);
        check32("rst_flush_done", {31'b0, flush_done_o}, 32'd0);
        check32("rst_pkt_cnt",    pkt_cnt_o,             32'd0);
        check32("rst_word_cnt",   word_cnt_o,            32'd0);
        rst_ni = 1'b1;
        chk_en = 1'b1;
        @(posedge clk_i);
        #1;

        // two 16-bit packets form one word
        send_pkt(128'hBEEF, 8'd16, 1'b0);
        send_pkt(128'hDEAD, 8'd16, 1'b0);
        wait_word(32'hDEADBEEF, "beef_dead_word");
`ifdef TRDB_SERIALIZER_CNT_EN
        check32("lit_pkt_cnt",  pkt_cnt_o,  32'd2);
        check32("lit_word_cnt", word_cnt_o, 32'd1);
`endif

        // full-width packet, sink toggling ready
        rdy_mode = 1;
        send_pkt(128'h01234567_89ABCDEF_DEADBEEF_CAFEF00D, 8'd128, 1'b0);
        wait_word(32'hCAFEF00D, "w128_0");
        wait_word(32'hDEADBEEF, "w128_1");
        wait_word(32'h89ABCDEF, "w128_2");
        wait_word(32'h01234567, "w128_3");
        rdy_mode = 0;

        // 5 + 7 bits then flush: padded partial word (payload has junk above len)
        send_pkt({PKT_W{1'b1}}, 8'd5, 1'b0);
        send_pkt(128'hCAFE_0000_0000_0000_0000_0000_0000_00D5, 8'd7, 1'b0);
        pulse_flush();
        wait_word(32'h00000ABF, "flush_partial_word");
        wait_done("flush_done_partial");

        // flush with an empty buffer: done two edges after the request
        pulse_flush();
        @(negedge clk_i);
        check32("empty_flush_early", {31'b0, flush_done_o}, 32'd0);
        check32("empty_flush_nowrd", {31'b0, word_valid_o}, 32'd0);
        @(negedge clk_i);
        check32("empty_flush_done",  {31'b0, flush_done_o}, 32'd1);
        @(posedge clk_i);
        #1;

        // zero-length packet is accepted and otherwise ignored
        send_pkt(128'hFFFF_FFFF, 8'd0, 1'b0);
        // over-long length clamps to the full width
        send_pkt({$urandom, $urandom, $urandom, $urandom}, 8'd200, 1'b0);
        repeat (6) @(posedge clk_i);
        #1;

        // asynchronous reset while a flush still has words pending
        rdy_mode = 3;
        send_pkt(128'h11112222_33334444_55556666_77778888, 8'd128, 1'b0);
        pulse_flush();
        repeat (3) @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check32("arst_pkt_ready",  {31'b0, pkt_ready_o},  32'd1);
        check32("arst_word_valid", {31'b0, word_valid_o}, 32'd0);
        check32("arst_word",       word_o,                32'd0);
        check32("arst_flush_done", {31'b0, flush_done_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni   = 1'b1;
        rdy_mode = 0;
        repeat (5) @(posedge clk_i);
        #1;

        // randomized traffic
        rdy_mode = 2;
        for (int k = 0; k < 300; k++) begin
            int          sel;
            logic [LEN_W-1:0] len;
            sel = $urandom_range(0, 9);
            if (sel == 0)      len = 8'd0;
            else if (sel == 1) len = 8'd128;
            else if (sel == 2) len = 8'($urandom_range(129, 255));
            else               len = 8'($urandom_range(1, 127));
            send_pkt({$urandom, $urandom, $urandom, $urandom}, len,
                     ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk_i);
                #1;
            end
            if ($urandom_range(0, 15) == 0) pulse_flush();
        end
        rdy_mode = 0;
        repeat (10) @(posedge clk_i);
        #1;
        pulse_flush();
        wait_done("final_flush_done");
        repeat (3) @(posedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global time bound
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
